// File: rtl/calc_pkg.sv
// Shared widths and ALU opcodes for the calculator register-file datapath.
package calc_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREGS = 4;

  // control[2] inverts operand B; control[1:0] picks AND / OR / SUM / SLT.
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_RSV  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

endpackage

// File: rtl/calculator_rf_if.sv
// Operand/command bundle between a driver and the calculator register file.
interface calculator_rf_if
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    we_addr;
  logic [2:0]       control;
  logic [WIDTH-1:0] immediate;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output rd_addr, we_addr, control, immediate,
    input  rd_data
  );

  modport slave (
    input  rd_addr, we_addr, control, immediate,
    output rd_data
  );
endinterface

// File: rtl/calc_alu.sv
// Combinational ALU: A op (optionally inverted) B, including signed set-less-than.
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  // Shared adder: with control[2] set, A + ~B + 1 is A - B, which SLT reuses.
  always_comb begin
    bx     = control[2] ? ~b : b;
    sum    = a + bx + {{(WIDTH-1){1'b0}}, control[2]};
    ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    result = '0;
    case (control)
      OP_AND:  result = a & bx;
      OP_OR:   result = a | bx;
      OP_ADD:  result = sum;
      OP_RSV:  result = '0;
      OP_ANDN: result = a & bx;
      OP_ORN:  result = a | bx;
      OP_SUB:  result = sum;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/calculator_rf.sv
// Register file whose addressed entry feeds the ALU; the result is written back every clock.
module calculator_rf
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS
) (
  input logic            clk,
  input logic            rst_n,
  calculator_rf_if.slave bus
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] alu_result;

  assign bus.rd_data = regs[bus.rd_addr];

  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .a       (regs[bus.rd_addr]),
    .b       (bus.immediate),
    .control (bus.control),
    .result  (alu_result)
  );

  // No write enable: every edge out of reset commits the ALU result to we_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      regs[bus.we_addr] <= alu_result;
    end
  end

endmodule

// File: tb/tb_calculator_rf.sv
// Directed bench for calculator_rf: hand-computed results for each opcode and corner case.
module tb_calculator_rf;
  import calc_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  calculator_rf_if #(.WIDTH(4), .NREGS(4)) bus ();

  calculator_rf #(.WIDTH(4), .NREGS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one command, let it be written at the next edge, sample 1 ns later.
  task automatic step(input logic [1:0] rd, input logic [1:0] we,
                      input logic [2:0] ctl, input logic [3:0] imm);
    bus.rd_addr   = rd;
    bus.we_addr   = we;
    bus.control   = ctl;
    bus.immediate = imm;
    @(posedge clk);
    #1;
  endtask

  task automatic load_r0(input logic [3:0] val);
    step(2'd0, 2'd0, OP_AND, 4'b0000);
    step(2'd0, 2'd0, OP_OR, val);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.we_addr   = 2'd0;
    bus.control   = OP_OR;
    bus.immediate = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = i[1:0];
      #1;
      checks++;
      if (bus.rd_data !== 4'b0000) begin
        errors++;
        $display("FAIL reset_r%0d got %b expected 0000", i, bus.rd_data);
      end
    end
    #8;
    rst_n = 1'b1;
  endtask

  task automatic test_accumulate();
    load_r0(4'b0000);
    step(2'd0, 2'd0, OP_OR, 4'b0101);
    checks++;
    if (bus.rd_data !== 4'b0101) begin
      errors++; $display("FAIL acc_or got %b expected 0101", bus.rd_data);
    end
    step(2'd0, 2'd0, OP_ADD, 4'b0011);
    checks++;
    if (bus.rd_data !== 4'b1000) begin
      errors++; $display("FAIL acc_add got %b expected 1000", bus.rd_data);
    end
    step(2'd0, 2'd0, OP_AND, 4'b1010);
    checks++;
    if (bus.rd_data !== 4'b1000) begin
      errors++; $display("FAIL acc_and got %b expected 1000", bus.rd_data);
    end
  endtask

  task automatic test_wrap_sub();
    load_r0(4'b1000);
    step(2'd0, 2'd0, OP_ADD, 4'b1111);
    checks++;
    if (bus.rd_data !== 4'b0111) begin
      errors++; $display("FAIL wrap_add got %b expected 0111", bus.rd_data);
    end
    step(2'd0, 2'd3, OP_SUB, 4'b0010);
    checks++;
    if (bus.rd_data !== 4'b0111) begin
      errors++; $display("FAIL sub_r0_kept got %b expected 0111", bus.rd_data);
    end
    bus.rd_addr = 2'd3;
    #1;
    checks++;
    if (bus.rd_data !== 4'b0101) begin
      errors++; $display("FAIL sub_r3 got %b expected 0101", bus.rd_data);
    end
  endtask

  task automatic test_inverted();
    load_r0(4'b1111);
    step(2'd0, 2'd0, OP_ANDN, 4'b0101);
    checks++;
    if (bus.rd_data !== 4'b1010) begin
      errors++; $display("FAIL andn got %b expected 1010", bus.rd_data);
    end
    load_r0(4'b0000);
    step(2'd0, 2'd0, OP_ORN, 4'b0011);
    checks++;
    if (bus.rd_data !== 4'b1100) begin
      errors++; $display("FAIL orn got %b expected 1100", bus.rd_data);
    end
  endtask

  task automatic test_slt();
    logic [3:0] a_v   [4] = '{4'b0111, 4'b1000, 4'b0101, 4'b0111};
    logic [3:0] b_v   [4] = '{4'b1111, 4'b0001, 4'b0101, 4'b1000};
    logic [3:0] exp_v [4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      load_r0(a_v[i]);
      step(2'd0, 2'd0, OP_SLT, b_v[i]);
      checks++;
      if (bus.rd_data !== exp_v[i]) begin
        errors++;
        $display("FAIL slt_%0d a=%b b=%b got %b expected %b",
                 i, a_v[i], b_v[i], bus.rd_data, exp_v[i]);
      end
    end
  endtask

  task automatic test_reserved_rdw();
    load_r0(4'b1010);
    bus.control   = OP_RSV;
    bus.immediate = 4'b1111;
    #1;
    checks++;
    if (bus.rd_data !== 4'b1010) begin
      errors++; $display("FAIL rsv_before_edge got %b expected 1010", bus.rd_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.rd_data !== 4'b0000) begin
      errors++; $display("FAIL rsv_written got %b expected 0000", bus.rd_data);
    end
    load_r0(4'b0011);
    bus.control   = OP_ADD;
    bus.immediate = 4'b0001;
    #1;
    checks++;
    if (bus.rd_data !== 4'b0011) begin
      errors++; $display("FAIL rdw_old got %b expected 0011", bus.rd_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.rd_data !== 4'b0100) begin
      errors++; $display("FAIL rdw_new got %b expected 0100", bus.rd_data);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) step(i[1:0], i[1:0], OP_OR, 4'b1111);
    checks++;
    if (bus.rd_data !== 4'b1111) begin
      errors++; $display("FAIL preload_r3 got %b expected 1111", bus.rd_data);
    end
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = i[1:0];
      #1;
      checks++;
      if (bus.rd_data !== 4'b0000) begin
        errors++;
        $display("FAIL async_reset_r%0d got %b expected 0000", i, bus.rd_data);
      end
    end
    bus.rd_addr   = 2'd0;
    bus.we_addr   = 2'd0;
    bus.control   = OP_OR;
    bus.immediate = 4'b0110;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.rd_data !== 4'b0110) begin
      errors++; $display("FAIL first_write_after_reset got %b expected 0110", bus.rd_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_accumulate();
    test_wrap_sub();
    test_inverted();
    test_slt();
    test_reserved_rdw();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calculator_rf.md
Name: calculator_rf

Overview:
- Small 4-entry × 4-bit register file with a 4-bit ALU.
- Each cycle, the ALU combines register operand A, selected by rd_addr, with a 4-bit immediate B according to a 3-bit control code.
- The result is written back to the register selected by we_addr on every rising clock edge.
- The register addressed by rd_addr is exposed combinationally on rd_data. Used as a standalone teaching datapath (ALU + register file) under a single clock.

Parameters:
- WIDTH, 4, data width of registers, immediate, ALU and rd_data
- NREGS, 4, number of registers (address width = clog2(NREGS) = 2)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  2  read address; also selects ALU operand A
- we_addr  in  2  write-back destination register
- control  in  3  ALU operation code
- immediate  in  WIDTH  ALU operand B
- rd_data  out  WIDTH  contents of reg[rd_addr]

Behaviour:
- Reset:
  - rst_n low clears all registers to 0 immediately, with no clock required.
  - rd_data therefore reads 0 while reset is held.
  - Release of reset is sampled normally; the first write occurs at the first rising edge with rst_n high.
- Read path:
  - rd_data = reg[rd_addr], purely combinational, zero latency.
  - Operand A = reg[rd_addr].
- Write path:
  - No separate write enable; every rising clk edge with rst_n high writes: reg[we_addr] <= alu_result.
  - rd_data reflects the new value after the edge (1-cycle latency from stimulus to visible result).
  - Read-during-write to the same address returns the old value until the edge.
  - Self-update (rd_addr == we_addr) uses the pre-edge value as A.
- ALU:
  - control[2] = invert B: Bx = control[2] ? ~immediate : immediate.
  - control[1:0] selects the function:
    - 00 AND: A & Bx
    - 01 OR: A | Bx
    - 10 SUM: A + Bx + control[2], truncated to WIDTH; carry-out discarded, wraps modulo 16.
  - Resulting opcodes:
    - 000 AND
    - 001 OR
    - 010 ADD
    - 100 A&~B
    - 101 A|~B
    - 110 SUB (A−B two's complement, wraps)
    - 111 SLT
  - 111 SLT:
    - result = {000, lt}, where lt = 1 iff A < B as signed two's-complement.
    - lt = diff[MSB] XOR overflow, with diff = A − B and overflow = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]).
  - 011 (reserved): result = 0 and is still written; verification treats it as legal.
- No flags output, no status registers.
- Inputs are expected stable around the rising edge; no internal input registering.

Decomposition:
- Shared package calc_pkg:
  - WIDTH and NREGS defaults
  - Opcode localparams: OP_AND=000, OP_OR=001, OP_ADD=010, OP_RSV=011, OP_ANDN=100, OP_ORN=101, OP_SUB=110, OP_SLT=111
- One natural sub-module: calc_alu (purely combinational; a, b, control -> result).
- The register file stays inline in calculator_rf.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after registers hold nonzero values -> rd_data=0000 for rd_addr 0..3 immediately, no clock edge needed.
- Accumulate on r0 (rd=we=00, start 0000):
  - OR imm 0101 -> 0101
  - ADD imm 0011 -> 1000
  - AND imm 1010 -> 1000
  - Each value visible on rd_data after one rising edge.
- Wrap and subtract:
  - r0=1000, ADD imm 1111 -> 0111 (carry dropped).
  - Then control 110 imm 0010 with we=11, rd=00 -> r3=0101, r0 unchanged (0111).
  - rd=11 then reads 0101.
- Inverted logic:
  - r0=1111, control 100 imm 0101 -> 1010.
  - r0=0000, control 101 imm 0011 -> 1100.
- SLT (signed):
  - r0=0111 vs imm 1111 (−1) -> 0000
  - r0=1000 (−8) vs imm 0001 -> 0001
  - r0=0101 vs imm 0101 -> 0000
  - r0=0111 vs imm 1000 (overflow case) -> 0000
- Reserved/read-during-write:
  - control 011 -> written value 0000.
  - With rd=we, rd_data shows the old value before the edge and the new value after it.
